dac_sample_fifo: RTL and testbench
==================================

DAC_SAMPLE_FIFO -- requirements
Module: dac_sample_fifo

Interface
REQ-001 SHALL have parameter DataWidth, default 12, sample width in bits; this matches the FIR output width.
REQ-002 SHALL have parameter Depth, default 4, number of entries; must be a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port inData, input, DataWidth bits: FIR output sample.
REQ-006 SHALL have port inValid, input, 1 bit: one-cycle strobe (FIR done) qualifying inData.
REQ-007 SHALL have port outReady, input, 1 bit: one-cycle request from the I2S controller for the next DAC sample.
REQ-008 SHALL have port outData, output, DataWidth bits: registered sample for the DAC.
REQ-009 SHALL have port outValid, output, 1 bit: one-cycle strobe marking outData updated.
REQ-010 SHALL have port level, output, clog2(Depth)+1 bits: current occupancy.
REQ-011 SHALL have ports full and empty, outputs, 1 bit each: combinational decode of level.
REQ-012 SHALL have ports overflow and underrun, outputs, 1 bit each: sticky error flags.
REQ-013 SHALL have port clearFlags, input, 1 bit: synchronous clear of the sticky flags.

Function
REQ-014 Write: inValid && !full SHALL store inData at the write pointer, advance the pointer (mod Depth), and increment level.
REQ-015 inValid && full && !outReady SHALL drop the incoming sample, leave contents unchanged, and set overflow.
REQ-016 Read: outReady && !empty SHALL load outData with the oldest entry on the next edge, pulse outValid for one cycle, advance the read pointer (mod Depth), and decrement level.
REQ-017 outReady && empty SHALL set underrun, pulse outValid, and load outData with the underrun value (see Configuration).
REQ-018 Simultaneous inValid and outReady with 0 < level < Depth SHALL perform both operations, leaving level unchanged.
REQ-019 Simultaneous inValid and outReady when full SHALL perform both operations with no overflow, leaving level equal to Depth.
REQ-020 Simultaneous inValid and outReady when empty SHALL treat the read as an underrun (no fall-through) and SHALL store the write, giving level 1.
REQ-021 Read latency SHALL be 1 cycle from outReady to outValid and outData.
REQ-022 Pointer wrap-around SHALL be seamless; order SHALL be strictly FIFO.
REQ-023 clearFlags SHALL clear overflow and underrun, and SHALL take precedence over a same-cycle set.
REQ-024 Data SHALL pass unmodified; there is no scaling or saturation in this block.

Reset
REQ-025 While reset is high, the pointers SHALL be 0, level SHALL be 0, outData SHALL be 0, and outValid, overflow and underrun SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard all entries on that edge; inValid and outReady SHALL be ignored during reset.
REQ-027 Storage array contents SHALL NOT require reset.

Configuration
REQ-028 Macro DAC_FIFO_ZERO_ON_UNDERRUN_EN defined: the underrun value SHALL be 0 (muted output).
REQ-029 Macro absent: the underrun value SHALL be the previous outData, so the last sample repeats.

Structure
REQ-030 DataWidth default, Depth default and the level width function SHALL live in the shared package fir_engine_pkg.
REQ-031 The block SHALL be a single module with no sub-module; the storage is an inferred register array.

Verification
REQ-032 Reset, then write 0x123, 0x456; then outReady twice -> outData 0x123 then 0x456, each one cycle after its request with outValid; level 2 -> 1 -> 0.
REQ-033 Five writes with Depth=4 and no reads -> full=1, overflow=1, fifth sample dropped; four reads return the first four samples in order.
REQ-034 Empty, outReady with outData previously 0x7FF -> underrun=1, outValid pulse; outData 0x000 with the macro, 0x7FF without.
REQ-035 Full, inValid and outReady in the same cycle -> oldest sample out, new sample stored, overflow stays 0, level 4.
REQ-036 Empty, inValid=0xABC and outReady in the same cycle -> underrun=1, level 1; the next outReady returns 0xABC.
REQ-037 Level 3, assert reset for one cycle -> level 0, empty=1, outData 0, flags 0; clearFlags together with overflow -> overflow 0.

Source files
------------

// File: rtl/fir_engine_pkg.sv
// fir_engine_pkg: shared widths, depths and sizing helpers for the FIR-to-DAC path
package fir_engine_pkg;
  localparam int DacDataWidth = 12;
  localparam int DacDepth = 4;
  function automatic int levelWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/dac_sample_fifo.sv
// dac_sample_fifo: FIR-to-I2S sample buffer with sticky overflow/underrun flags
// DAC_FIFO_ZERO_ON_UNDERRUN_EN: mute on underrun instead of repeating the last sample
module dac_sample_fifo
  import fir_engine_pkg::*;
#(
  parameter int DataWidth = DacDataWidth,
  parameter int Depth = DacDepth
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DataWidth-1:0]          inData,
  input  logic                          inValid,
  input  logic                          outReady,
  output logic [DataWidth-1:0]          outData,
  output logic                          outValid,
  output logic [levelWidth(Depth)-1:0]  level,
  output logic                          full,
  output logic                          empty,
  output logic                          overflow,
  output logic                          underrun,
  input  logic                          clearFlags
);
  localparam int LevelW = levelWidth(Depth);
  localparam int PtrW = $clog2(Depth);
  logic [DataWidth-1:0] mem [Depth];
  logic [PtrW-1:0] wrPtr, rdPtr;
  logic doWrite, doRead, overflowSet, underrunSet;
  logic [DataWidth-1:0] underrunValue;
  assign full = level == LevelW'(Depth);
  assign empty = level == '0;
`ifdef DAC_FIFO_ZERO_ON_UNDERRUN_EN
  assign underrunValue = '0;
`else
  assign underrunValue = outData;
`endif
  // A full FIFO still accepts a write when a read frees a slot on the same edge
  always_comb begin
    doRead = outReady && !empty;
    doWrite = inValid && (!full || outReady);
    overflowSet = inValid && full && !outReady;
    underrunSet = outReady && empty;
  end
  always_ff @(posedge clk)
    if (doWrite && !reset) mem[wrPtr] <= inData;
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
      outData <= '0;
      outValid <= 1'b0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      wrPtr <= doWrite ? wrPtr + 1'b1 : wrPtr;
      rdPtr <= doRead ? rdPtr + 1'b1 : rdPtr;
      level <= level + LevelW'(doWrite) - LevelW'(doRead);
      outData <= doRead ? mem[rdPtr] : (outReady ? underrunValue : outData);
      outValid <= outReady;
      overflow <= clearFlags ? 1'b0 : (overflow | overflowSet);
      underrun <= clearFlags ? 1'b0 : (underrun | underrunSet);
    end
  end
endmodule

// File: tb/tb_dac_sample_fifo.sv
// tb_dac_sample_fifo: directed checks of ordering, full/empty corners, flags and reset
module tb_dac_sample_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [11:0] inData = '0;
  logic inValid = 1'b0;
  logic outReady = 1'b0;
  logic clearFlags = 1'b0;
  logic [11:0] outData;
  logic outValid;
  logic [2:0] level;
  logic full, empty, overflow, underrun;
  int tests = 0;
  int fails = 0;
  logic [11:0] expMute;

  dac_sample_fifo dut (
    .clk(clk), .reset(reset), .inData(inData), .inValid(inValid),
    .outReady(outReady), .outData(outData), .outValid(outValid),
    .level(level), .full(full), .empty(empty), .overflow(overflow),
    .underrun(underrun), .clearFlags(clearFlags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [11:0] d, input logic r, input logic c, input logic rs);
    inValid = v;
    inData = d;
    outReady = r;
    clearFlags = c;
    reset = rs;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    outReady = 1'b0;
    clearFlags = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    step(1, 12'hFFF, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_outData", outData, 0);
    chk("rst_outValid", outValid, 0);
    chk("rst_flags", {overflow, underrun}, 0);
    // two writes then two reads
    step(1, 12'h123, 0, 0, 0);
    chk("w1_level", level, 1);
    step(1, 12'h456, 0, 0, 0);
    chk("w2_level", level, 2);
    step(0, 0, 1, 0, 0);
    chk("r1_data", outData, 12'h123);
    chk("r1_valid", outValid, 1);
    chk("r1_level", level, 1);
    step(0, 0, 1, 0, 0);
    chk("r2_data", outData, 12'h456);
    chk("r2_level", level, 0);
    chk("r2_empty", empty, 1);
    step(0, 0, 0, 0, 0);
    chk("idle_valid", outValid, 0);
    chk("idle_data_hold", outData, 12'h456);
    // underrun with previous outData 0x7FF
    step(1, 12'h7FF, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("pre_und_data", outData, 12'h7FF);
`ifdef DAC_FIFO_ZERO_ON_UNDERRUN_EN
    expMute = 12'h000;
`else
    expMute = 12'h7FF;
`endif
    step(0, 0, 1, 0, 0);
    chk("und_flag", underrun, 1);
    chk("und_valid", outValid, 1);
    chk("und_data", outData, expMute);
    chk("und_level", level, 0);
    step(0, 0, 0, 1, 0);
    chk("und_clear", underrun, 0);
    // five writes into a four-deep FIFO
    step(1, 12'h101, 0, 0, 0);
    step(1, 12'h102, 0, 0, 0);
    step(1, 12'h103, 0, 0, 0);
    step(1, 12'h104, 0, 0, 0);
    chk("fill_full", full, 1);
    chk("fill_ovf0", overflow, 0);
    step(1, 12'h105, 0, 0, 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_level", level, 4);
    // clear wins over a same-cycle overflow; sample 0x999 is dropped
    step(1, 12'h999, 0, 1, 0);
    chk("clr_prec", overflow, 0);
    chk("clr_level", level, 4);
    // full: simultaneous write and read
    step(1, 12'h200, 1, 0, 0);
    chk("fullrw_data", outData, 12'h101);
    chk("fullrw_valid", outValid, 1);
    chk("fullrw_ovf", overflow, 0);
    chk("fullrw_level", level, 4);
    step(0, 0, 1, 0, 0);
    chk("drain1", outData, 12'h102);
    step(0, 0, 1, 0, 0);
    chk("drain2", outData, 12'h103);
    step(0, 0, 1, 0, 0);
    chk("drain3", outData, 12'h104);
    step(0, 0, 1, 0, 0);
    chk("drain4", outData, 12'h200);
    chk("drain_empty", empty, 1);
    chk("drain_und", underrun, 0);
    // empty: simultaneous write and read is an underrun plus a store
`ifdef DAC_FIFO_ZERO_ON_UNDERRUN_EN
    expMute = 12'h000;
`else
    expMute = 12'h200;
`endif
    step(1, 12'hABC, 1, 0, 0);
    chk("emptyrw_und", underrun, 1);
    chk("emptyrw_level", level, 1);
    chk("emptyrw_data", outData, expMute);
    step(0, 0, 1, 0, 0);
    chk("emptyrw_next", outData, 12'hABC);
    chk("emptyrw_lvl0", level, 0);
    // partial level: simultaneous write and read keeps level
    step(1, 12'h011, 0, 0, 0);
    step(1, 12'h022, 0, 0, 0);
    step(1, 12'h033, 1, 0, 0);
    chk("mid_data", outData, 12'h011);
    chk("mid_level", level, 2);
    step(1, 12'h044, 0, 0, 0);
    chk("mid_level3", level, 3);
    // reset mid-operation with strobes asserted
    step(1, 12'h055, 1, 0, 1);
    chk("mrst_level", level, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_data", outData, 0);
    chk("mrst_valid", outValid, 0);
    chk("mrst_flags", {overflow, underrun}, 0);
    step(0, 0, 1, 0, 0);
    chk("post_rst_und", underrun, 1);
    chk("post_rst_data", outData, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
